// File: rtl/acc_mem_server.sv
// acc_mem_server: wrapper read/write handshake to single-beat valid/ready memory bus; MEM_TIMEOUT_EN adds a response watchdog
module acc_mem_server #(
  parameter int ADDR_W = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_enable,
  input  logic [63:0]       read_addr,
  input  logic              finish_read,
  output logic [63:0]       read_ready,
  output logic [31:0]       read_data,
  input  logic              write_enable,
  input  logic [63:0]       write_addr,
  input  logic [31:0]       write_data,
  input  logic              finish_write,
  output logic [63:0]       write_ready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_DONE, WR_REQ, WR_WAIT, WR_DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic rd_pulse, wr_pulse, ld_rd, ld_wr, timeout, rsp_ok;
  logic unused;
  assign rsp_ok = mem_rsp_valid | timeout;
  always_comb begin
    state_nx = state;
    ld_rd = 1'b0;
    ld_wr = 1'b0;
    case (state)
      IDLE: begin
        ld_rd = read_enable;
        ld_wr = !read_enable && write_enable;
        state_nx = read_enable ? RD_REQ : write_enable ? WR_REQ : IDLE;
      end
      RD_REQ:  state_nx = mem_req_ready ? RD_WAIT : RD_REQ;
      RD_WAIT: state_nx = rsp_ok ? RD_DONE : RD_WAIT;
      RD_DONE: begin
        ld_rd = finish_read;
        state_nx = finish_read ? RD_REQ : read_enable ? RD_DONE : IDLE;
      end
      WR_REQ:  state_nx = mem_req_ready ? WR_WAIT : WR_REQ;
      WR_WAIT: state_nx = rsp_ok ? WR_DONE : WR_WAIT;
      WR_DONE: begin
        ld_wr = finish_write;
        state_nx = finish_write ? WR_REQ : write_enable ? WR_DONE : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_pulse <= 1'b0;
      wr_pulse <= 1'b0;
    end else begin
      state <= state_nx;
      if (ld_rd) addr_q <= read_addr[ADDR_W+1:2];
      if (ld_wr) begin
        addr_q <= write_addr[ADDR_W+1:2];
        wdata_q <= write_data;
      end
      if (state == RD_WAIT && rsp_ok) rdata_q <= mem_rsp_valid ? mem_rsp_rdata : 32'hDEADBEEF;
      rd_pulse <= state == RD_WAIT && rsp_ok;
      wr_pulse <= state == WR_WAIT && rsp_ok;
    end
  end
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic err_q, waiting;
  assign waiting = state == RD_WAIT || state == WR_WAIT;
  assign timeout = waiting && !mem_rsp_valid && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= waiting && !rsp_ok ? cnt + 1'b1 : '0;
      err_q <= err_q | timeout;
    end
  end
  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
  assign mem_req_valid = state == RD_REQ || state == WR_REQ;
  assign mem_req_we = state == WR_REQ;
  assign mem_req_addr = addr_q;
  assign mem_req_wdata = wdata_q;
  assign read_data = rdata_q;
  assign read_ready = {63'b0, rd_pulse};
  assign write_ready = {63'b0, wr_pulse};
  assign unused = ^{read_addr[63:ADDR_W+2], read_addr[1:0], write_addr[63:ADDR_W+2], write_addr[1:0]} ^ (TIMEOUT_CYC == 0);
endmodule

// File: tb/tb_acc_mem_server.sv
// tb_acc_mem_server: directed vectors and sequences against a one-cycle-response memory model
module tb_acc_mem_server;
  logic clk = 0, reset = 1;
  logic read_enable = 0, finish_read = 0, write_enable = 0, finish_write = 0;
  logic [63:0] read_addr = 0, write_addr = 0, read_ready, write_ready;
  logic [31:0] write_data = 0, read_data, mem_req_wdata, mem_rsp_rdata;
  logic mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid, err;
  logic [15:0] mem_req_addr;
  logic stall = 0, rsp_en = 1, inj_rsp = 0, rsp_q = 0;
  logic [31:0] rdata_q = 0;
  logic [31:0] mem [0:65535];
  int n_chk = 0, n_err = 0, n_req = 0, n_rdp = 0, n_wrp = 0, dbl = 0, upper_bad = 0;
  logic [15:0] last_addr = 0;
  logic last_we = 0, prev_rr = 0, prev_wr = 0;
  logic [31:0] last_wdata = 0;

  always #5 clk = ~clk;

  acc_mem_server #(.ADDR_W(16), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .read_enable(read_enable), .read_addr(read_addr), .finish_read(finish_read),
    .read_ready(read_ready), .read_data(read_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .finish_write(finish_write), .write_ready(write_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .err(err)
  );

  assign mem_req_ready = !stall;
  assign mem_rsp_valid = rsp_q | inj_rsp;
  assign mem_rsp_rdata = rdata_q;

  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      n_req++;
      last_addr = mem_req_addr;
      last_we = mem_req_we;
      last_wdata = mem_req_wdata;
      if (mem_req_we) mem[mem_req_addr] = mem_req_wdata;
      rdata_q <= mem[mem_req_addr];
      rsp_q <= rsp_en;
    end else
      rsp_q <= 1'b0;
    if (read_ready[0]) n_rdp++;
    if (write_ready[0]) n_wrp++;
    if (read_ready[0] && prev_rr) dbl++;
    if (write_ready[0] && prev_wr) dbl++;
    if (read_ready[63:1] != 0 || write_ready[63:1] != 0) upper_bad++;
    prev_rr = read_ready[0];
    prev_wr = write_ready[0];
  end

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [15:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_pulse(input bit rd, input string nm);
    int i;
    for (i = 0; i < 30 && !(rd ? read_ready[0] : write_ready[0]); i++) tick;
    chk(nm, 64'(i < 30), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int r0, w0;
    r0 = n_rdp;
    w0 = n_wrp;
    read_enable = v.rd;
    read_addr = v.addr;
    write_enable = v.wr;
    write_addr = v.addr;
    write_data = v.wdata;
    wait_pulse(v.rd, $sformatf("vec%0d_done", idx));
    read_enable = 0;
    write_enable = 0;
    tick;
    tick;
    chk($sformatf("vec%0d_addr", idx), 64'(last_addr), 64'(v.exp_addr));
    chk($sformatf("vec%0d_we", idx), 64'(last_we), 64'(v.exp_we));
    chk($sformatf("vec%0d_pulses", idx), 64'({n_rdp - r0, n_wrp - w0}), {32'(v.rd), 32'(!v.rd)});
    if (v.rd) chk($sformatf("vec%0d_rdata", idx), 64'(read_data), 64'(v.exp_data));
    else begin
      chk($sformatf("vec%0d_wdata", idx), 64'(last_wdata), 64'(v.exp_data));
      chk($sformatf("vec%0d_mem", idx), 64'(mem[v.exp_addr]), 64'(v.exp_data));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0, w0, q0;
    vecs[0] = '{1'b1, 1'b0, 64'h40, 32'h0, 16'h0010, 1'b0, 32'h12345678};
    vecs[1] = '{1'b1, 1'b0, 64'h43, 32'h0, 16'h0010, 1'b0, 32'h12345678};
    vecs[2] = '{1'b1, 1'b0, 64'h1_2340_0044, 32'h0, 16'h0011, 1'b0, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b0, 64'hFFFC, 32'h0, 16'h3FFF, 1'b0, 32'h0BADC0DE};
    vecs[4] = '{1'b0, 1'b1, 64'h400, 32'h5A5A0001, 16'h0100, 1'b1, 32'h5A5A0001};
    vecs[5] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_0007, 32'h00000042, 16'hC001, 1'b1, 32'h00000042};
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[16'h0010] = 32'h12345678;
    mem[16'h0011] = 32'hCAFEF00D;
    mem[16'h3FFF] = 32'h0BADC0DE;
    for (int i = 0; i < 4; i++) mem[16'h0040 + i] = 32'h1000 + i;
    tick;
    tick;
    chk("rst_ready", read_ready | write_ready, 64'h0);
    chk("rst_req", {45'h0, mem_req_valid, mem_req_we, mem_req_addr}, 64'h0);
    chk("rst_data", {read_data, mem_req_wdata}, 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    reset = 0;
    tick;
    // single read with exact cycle timing
    read_enable = 1;
    read_addr = 64'h40;
    tick;
    chk("rd1_req", {46'h0, mem_req_valid, mem_req_we, mem_req_addr}, {46'h0, 1'b1, 1'b0, 16'h0010});
    tick;
    chk("rd1_wait", {63'h0, mem_req_valid} | read_ready, 64'h0);
    tick;
    chk("rd1_pulse", read_ready, 64'h1);
    chk("rd1_data", 64'(read_data), 64'h12345678);
    read_enable = 0;
    tick;
    chk("rd1_pulse_end", read_ready, 64'h0);
    chk("rd1_hold", 64'(read_data), 64'h12345678);
    tick;
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    chk("rd_hold_after_wr", 64'(read_data), 64'h0BADC0DE);
    // burst of 4 reads with finish_read
    r0 = n_rdp;
    q0 = n_req;
    read_enable = 1;
    read_addr = 64'h100;
    for (int i = 0; i < 4; i++) begin
      wait_pulse(1, $sformatf("burst%0d_done", i));
      chk($sformatf("burst%0d_data", i), 64'(read_data), 64'(32'h1000 + i));
      chk($sformatf("burst%0d_addr", i), 64'(last_addr), 64'(16'h0040 + i));
      if (i < 3) begin
        read_addr += 4;
        finish_read = 1;
        tick;
        finish_read = 0;
        chk($sformatf("burst%0d_next_req", i), {47'h0, mem_req_valid, mem_req_addr}, {47'h0, 1'b1, 16'h0041 + 16'(i)});
      end
    end
    read_enable = 0;
    tick;
    tick;
    chk("burst_counts", {32'(n_rdp - r0), 32'(n_req - q0)}, {32'd4, 32'd4});
    chk("burst_idle", 64'(mem_req_valid), 64'h0);
    // three writes with finish_write
    w0 = n_wrp;
    q0 = n_req;
    write_enable = 1;
    write_addr = 64'h200;
    write_data = 32'hA0;
    for (int i = 0; i < 3; i++) begin
      wait_pulse(0, $sformatf("wr%0d_done", i));
      chk($sformatf("wr%0d_req", i), {15'h0, last_we, last_addr, last_wdata}, {15'h0, 1'b1, 16'h0080 + 16'(i), 32'hA0 + 32'(i)});
      if (i < 2) begin
        write_addr += 4;
        write_data += 1;
        finish_write = 1;
        tick;
        finish_write = 0;
      end
    end
    write_enable = 0;
    tick;
    tick;
    chk("wr_counts", {32'(n_wrp - w0), 32'(n_req - q0)}, {32'd3, 32'd3});
    chk("wr_mem", {mem[16'h0081], mem[16'h0082]}, {32'hA1, 32'hA2});
    // backpressure: request must hold steady while ready is low
    q0 = n_req;
    stall = 1;
    write_enable = 1;
    write_addr = 64'h300;
    write_data = 32'h55AA;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), {14'h0, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, {14'h0, 1'b1, 1'b1, 16'h00C0, 32'h55AA});
      tick;
    end
    chk("bp_none_accepted", 64'(n_req - q0), 64'd0);
    stall = 0;
    wait_pulse(0, "bp_done");
    write_enable = 0;
    tick;
    tick;
    chk("bp_one_accepted", 64'(n_req - q0), 64'd1);
    // simultaneous enables: read first, write once read drops
    w0 = n_wrp;
    read_enable = 1;
    read_addr = 64'h40;
    write_enable = 1;
    write_addr = 64'h204;
    write_data = 32'h77;
    wait_pulse(1, "both_rd_done");
    chk("both_rd_first", {31'h0, last_we, 16'h0, last_addr}, {31'h0, 1'b0, 16'h0, 16'h0010});
    chk("both_no_wr_yet", 64'(n_wrp - w0), 64'd0);
    read_enable = 0;
    wait_pulse(0, "both_wr_done");
    write_enable = 0;
    chk("both_wr_req", {15'h0, last_we, last_addr, last_wdata}, {15'h0, 1'b1, 16'h0081, 32'h77});
    tick;
    tick;
    // asynchronous reset while waiting for a response; the late response is ignored
    rsp_en = 0;
    read_enable = 1;
    read_addr = 64'h44;
    tick;
    tick;
    chk("arst_pre", 64'(read_data), 64'h12345678);
    #3 reset = 1;
    #1;
    chk("arst_outputs", {15'h0, mem_req_valid, mem_req_addr, read_data}, 64'h0);
    chk("arst_ready", read_ready | write_ready, 64'h0);
    read_enable = 0;
    tick;
    reset = 0;
    r0 = n_rdp;
    inj_rsp = 1;
    tick;
    inj_rsp = 0;
    tick;
    tick;
    chk("late_rsp_ignored", {32'(n_rdp - r0), read_data}, 64'h0);
    // no response at all
    r0 = n_rdp;
    read_enable = 1;
    read_addr = 64'h40;
`ifdef MEM_TIMEOUT_EN
    wait_pulse(1, "to_done");
    chk("to_err", 64'(err), 64'h1);
    chk("to_data", 64'(read_data), 64'hDEADBEEF);
    read_enable = 0;
    tick;
    tick;
    chk("to_err_sticky", 64'(err), 64'h1);
`else
    for (int i = 0; i < 20; i++) tick;
    chk("nto_waits", 64'(n_rdp - r0), 64'd0);
    chk("nto_err", 64'(err), 64'h0);
    read_enable = 0;
`endif
    reset = 1;
    tick;
    reset = 0;
    rsp_en = 1;
    tick;
    chk("final_err_clear", 64'(err), 64'h0);
    chk("pulse_single_cycle", 64'(dbl), 64'd0);
    chk("ready_upper_zero", 64'(upper_bad), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
